// File: rtl/cache_refill_unit.sv
// Line refill engine for a direct-mapped cache.
// On a miss it invalidates the tag entry, then fetches the four words of the line one at a time.
// Each word goes into the data array, and the entry is then written back as valid.
// Completion is returned on a four-phase request/done handshake.
// Every output is a register, so no input reaches an output combinationally.
module cache_refill_unit #(
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned INDEX_W = 3,
  parameter int unsigned OFF_W   = 2,
  parameter int unsigned WORD_W  = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             miss_req_i,
  input  logic [TAG_W-1:0]                 miss_tag_i,
  input  logic [INDEX_W-1:0]               miss_index_i,
  output logic                             mem_rd_o,
  output logic [TAG_W+INDEX_W+OFF_W-1:0]   mem_addr_o,
  input  logic [WORD_W-1:0]                mem_rdata_i,
  input  logic                             mem_ready_i,
  output logic                             data_we_o,
  output logic [INDEX_W+OFF_W-1:0]         data_addr_o,
  output logic [WORD_W-1:0]                data_wdata_o,
  output logic                             tag_we_o,
  output logic [INDEX_W-1:0]               tag_index_o,
  output logic [TAG_W:0]                   tag_wdata_o,
  output logic                             busy_o,
  output logic                             refill_done_o
);

  typedef enum logic [2:0] {StIdle, StInval, StReq, StWrite, StTagWr, StDone} state_e;

  state_e                           state_q;
  logic [TAG_W-1:0]                 tag_q;
  logic [INDEX_W-1:0]               index_q;
  logic [OFF_W-1:0]                 off_q;
  logic [WORD_W-1:0]                buf_q;
  logic                             mem_rd_q;
  logic [TAG_W+INDEX_W+OFF_W-1:0]   mem_addr_q;
  logic                             data_we_q;
  logic [INDEX_W+OFF_W-1:0]         data_addr_q;
  logic                             tag_we_q;
  logic [INDEX_W-1:0]               tag_index_q;
  logic [TAG_W:0]                   tag_wdata_q;
  logic                             busy_q;
  logic                             done_q;
  logic [OFF_W-1:0]                 off_inc;

  assign off_inc = off_q + OFF_W'(1);

  // FSM and its registered outputs. Each branch loads the outputs that belong to the state
  // being entered, so the outputs line up with state_q in the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      tag_q       <= '0;
      index_q     <= '0;
      off_q       <= '0;
      buf_q       <= '0;
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      data_we_q   <= 1'b0;
      data_addr_q <= '0;
      tag_we_q    <= 1'b0;
      tag_index_q <= '0;
      tag_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Write strobes are single-cycle pulses. Addresses read as zero while idle.
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      data_we_q   <= 1'b0;
      data_addr_q <= '0;
      tag_we_q    <= 1'b0;
      tag_index_q <= '0;
      tag_wdata_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (miss_req_i) begin
            state_q     <= StInval;
            tag_q       <= miss_tag_i;
            index_q     <= miss_index_i;
            off_q       <= '0;
            busy_q      <= 1'b1;
            tag_we_q    <= 1'b1;
            tag_index_q <= miss_index_i;
            tag_wdata_q <= {1'b0, miss_tag_i};
          end
        end
        StInval: begin
          state_q    <= StReq;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= {tag_q, index_q, off_q};
        end
        StReq: begin
          if (mem_ready_i) begin
            state_q     <= StWrite;
            buf_q       <= mem_rdata_i;
            data_we_q   <= 1'b1;
            data_addr_q <= {index_q, off_q};
          end else begin
            mem_rd_q   <= 1'b1;
            mem_addr_q <= mem_addr_q;
          end
        end
        StWrite: begin
          if (off_q == '1) begin
            state_q     <= StTagWr;
            tag_we_q    <= 1'b1;
            tag_index_q <= index_q;
            tag_wdata_q <= {1'b1, tag_q};
          end else begin
            state_q    <= StReq;
            off_q      <= off_inc;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= {tag_q, index_q, off_inc};
          end
        end
        StTagWr: begin
          state_q <= StDone;
          done_q  <= 1'b1;
        end
        StDone: begin
          if (!miss_req_i) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd_o      = mem_rd_q;
  assign mem_addr_o    = mem_addr_q;
  assign data_we_o     = data_we_q;
  assign data_addr_o   = data_addr_q;
  assign data_wdata_o  = buf_q;
  assign tag_we_o      = tag_we_q;
  assign tag_index_o   = tag_index_q;
  assign tag_wdata_o   = tag_wdata_q;
  assign busy_o        = busy_q;
  assign refill_done_o = done_q;

endmodule

// File: tb/tb_cache_refill_unit.sv
// Scoreboard bench for cache_refill_unit.
// Stimulus tasks queue the expected memory reads, data writes, tag writes and done latency.
// A negedge monitor checks every output event against those queues.
module tb_cache_refill_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_req = 1'b0;
  logic [7:0]  miss_tag = '0;
  logic [2:0]  miss_index = '0;
  logic        mem_rd;
  logic [12:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic        mem_ready = 1'b0;
  logic        data_we;
  logic [4:0]  data_addr;
  logic [7:0]  data_wdata;
  logic        tag_we;
  logic [2:0]  tag_index;
  logic [8:0]  tag_wdata;
  logic        busy;
  logic        refill_done;

  cache_refill_unit #(
    .TAG_W   (8),
    .INDEX_W (3),
    .OFF_W   (2),
    .WORD_W  (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .miss_req_i    (miss_req),
    .miss_tag_i    (miss_tag),
    .miss_index_i  (miss_index),
    .mem_rd_o      (mem_rd),
    .mem_addr_o    (mem_addr),
    .mem_rdata_i   (mem_rdata),
    .mem_ready_i   (mem_ready),
    .data_we_o     (data_we),
    .data_addr_o   (data_addr),
    .data_wdata_o  (data_wdata),
    .tag_we_o      (tag_we),
    .tag_index_o   (tag_index),
    .tag_wdata_o   (tag_wdata),
    .busy_o        (busy),
    .refill_done_o (refill_done)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [7:0]  mem_base = '0;
  int          stall_word = -1;
  int          stall_left = 0;
  bit          noise = 1'b0;
  logic [12:0] exp_mem[$];
  logic [12:0] exp_data[$];
  logic [11:0] exp_tag[$];
  int          exp_lat[$];
  logic [8:0]  tag_model [8];

  // Memory returns base + word offset.
  assign mem_rdata = mem_base + {6'd0, mem_addr[1:0]};

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {21'd0, mem_rd, mem_addr, data_we, data_addr, data_wdata, tag_we, tag_index,
            tag_wdata, busy, refill_done};
  endfunction

  // Memory ready model: optional stall on one word, random toggling outside REQ when noisy.
  always @(negedge clk) begin
    if (mem_rd && stall_left > 0 && int'(mem_addr[1:0]) == stall_word) begin
      mem_ready = 1'b0;
      stall_left--;
    end else if (mem_rd) begin
      mem_ready = 1'b1;
    end else begin
      mem_ready = noise ? 1'($urandom) : 1'b0;
    end
  end

  // Monitor: pops and compares whenever the DUT presents an event.
  bit busy_prev = 1'b0;
  bit done_prev = 1'b0;
  int acc_cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      busy_prev = 1'b0;
      done_prev = 1'b0;
    end else begin
      if (busy && !busy_prev) acc_cyc = cyc;
      if (mem_rd) begin
        if (exp_mem.size() == 0) check("unexpected_mem_rd", 64'(mem_rd), 64'd0);
        else check("mem_addr", 64'(mem_addr), 64'(exp_mem.pop_front()));
      end else if (mem_addr != '0) begin
        check("mem_addr_idle_zero", 64'(mem_addr), 64'd0);
      end
      if (data_we) begin
        if (exp_data.size() == 0) check("unexpected_data_we", 64'(data_we), 64'd0);
        else check("data_write", 64'({data_addr, data_wdata}), 64'(exp_data.pop_front()));
      end
      if (tag_we) begin
        tag_model[tag_index] = tag_wdata;
        if (exp_tag.size() == 0) check("unexpected_tag_we", 64'(tag_we), 64'd0);
        else check("tag_write", 64'({tag_index, tag_wdata}), 64'(exp_tag.pop_front()));
      end
      // Done is seen after edge cyc, so it is present at edge cyc+1.
      if (refill_done && !done_prev) begin
        if (exp_lat.size() == 0) check("unexpected_done", 64'(refill_done), 64'd0);
        else check("done_latency", 64'(cyc + 1 - acc_cyc), 64'(exp_lat.pop_front()));
      end
      busy_prev = busy;
      done_prev = refill_done;
    end
  end

  // Queue a full refill's expectations and raise miss_req; returns just after acceptance.
  task automatic start_refill(input logic [7:0] tg, input logic [2:0] ix, input logic [7:0] base,
                              input int sw, input int sn);
    mem_base   = base;
    stall_word = sw;
    stall_left = sn;
    exp_tag.push_back({ix, 1'b0, tg});
    for (int o = 0; o < 4; o++) begin
      for (int r = 0; r <= ((o == sw) ? sn : 0); r++) exp_mem.push_back({tg, ix, 2'(o)});
      exp_data.push_back({ix, 2'(o), 8'(base + 8'(o))});
    end
    exp_tag.push_back({ix, 1'b1, tg});
    exp_lat.push_back(11 + sn);
    miss_tag   = tg;
    miss_index = ix;
    miss_req   = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input bit scramble);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (scramble) begin
        miss_tag   = 8'($urandom);
        miss_index = 3'($urandom);
      end
      if (refill_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("done_timeout", 64'(refill_done), 64'd1);
  endtask

  task automatic drop_req();
    miss_req = 1'b0;
    @(posedge clk); #1;
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_done", 64'(refill_done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    #3;
    check("reset_outputs", all_outs(), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero-wait refill, then hold miss_req in DONE for 5 cycles.
    start_refill(8'hA5, 3'd2, 8'h10, -1, 0);
    wait_done(1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_done", 64'(refill_done), 64'd1);
      check("hold_busy", 64'(busy), 64'd1);
    end
    drop_req();
    check("tag_valid_a5", 64'(tag_model[2]), 64'h1A5);

    // Three wait states on word 1.
    start_refill(8'hA5, 3'd2, 8'h20, 1, 3);
    wait_done(1'b0);
    drop_req();

    // Request inputs scrambled and mem_ready toggled outside REQ.
    noise = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start_refill(8'h3C, 3'd5, 8'h40, -1, 0);
    wait_done(1'b1);
    drop_req();
    repeat (3) @(posedge clk);
    #1;
    noise = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset during REQ of word 2: only the invalidate and words 0 and 1 are written.
    mem_base   = 8'h50;
    stall_word = -1;
    stall_left = 0;
    exp_tag.push_back({3'd6, 1'b0, 8'hA5});
    exp_mem.push_back({8'hA5, 3'd6, 2'd0});
    exp_mem.push_back({8'hA5, 3'd6, 2'd1});
    exp_data.push_back({3'd6, 2'd0, 8'h50});
    exp_data.push_back({3'd6, 2'd1, 8'h51});
    miss_tag   = 8'hA5;
    miss_index = 3'd6;
    miss_req   = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (mem_rd && mem_addr[1:0] == 2'd2) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("word2_timeout", 64'(mem_rd), 64'd1);
    rst      = 1'b1;
    miss_req = 1'b0;
    #1;
    check("reset_mid_outputs", all_outs(), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held_outputs", all_outs(), 64'd0);
    check("tag_stays_invalid", 64'(tag_model[6]), 64'h0A5);
    rst = 1'b0;
    @(posedge clk); #1;

    // Refill after reset starts from offset 0.
    start_refill(8'h77, 3'd6, 8'h60, -1, 0);
    wait_done(1'b0);
    drop_req();
    check("tag_valid_77", 64'(tag_model[6]), 64'h177);

    repeat (3) @(posedge clk);
    #1;
    check("mem_queue_empty", 64'(exp_mem.size()), 64'd0);
    check("data_queue_empty", 64'(exp_data.size()), 64'd0);
    check("tag_queue_empty", 64'(exp_tag.size()), 64'd0);
    check("done_queue_empty", 64'(exp_lat.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
